// File: rtl/freq_div_pkg.sv
// Shared clock-rate constants and divisor helper for the programmable divider.
package freq_div_pkg;

  localparam int unsigned CLK_HZ      = 40000000;
  localparam int unsigned DIV_1HZ     = 20000000;
  localparam int unsigned DIV_100HZ   = 200000;
  localparam int unsigned SCN_PRE_DEF = 15;

  // clk_cnt toggles once per divisor cycles, so its frequency is CLK_HZ/(2*div).
  function automatic int unsigned div_for_hz(input int unsigned hz);
    if (hz == 0) begin
      return 0;
    end
    return CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/freq_div_prog_scan_cnt.sv
// Display scan index: free-running prescaler advancing a modulo-SCN_N index.
// scn_tick is registered, aligned with the cycle clk_scn shows its new value.
module scan_cnt
  import freq_div_pkg::*;
#(
  parameter int SCN_W     = 2,
  parameter int SCN_N     = 4,
  parameter int SCN_PRE_W = SCN_PRE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [SCN_W-1:0] clk_scn,
  output logic             scn_tick
);

  logic [SCN_PRE_W-1:0] r_pre;
  logic [SCN_W-1:0]     r_scn;
  logic                 r_tick;
  logic                 w_pre_wrap;

  assign w_pre_wrap = &r_pre;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_scn  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= r_pre + 1'b1;
      r_tick <= w_pre_wrap;
      if (w_pre_wrap) begin
        r_scn <= (r_scn == SCN_W'(SCN_N - 1)) ? '0 : r_scn + 1'b1;
      end
    end
  end

  assign clk_scn  = r_scn;
  assign scn_tick = r_tick;

endmodule

// File: rtl/freq_div_prog.sv
// Programmable clock-enable tick and 50% divided clock, plus display scan index.
// Tick is registered one cycle after terminal count; new divisors only take effect at a wrap.
module freq_div_prog
  import freq_div_pkg::*;
#(
  parameter int          CNT_W     = 25,
  parameter int unsigned DEF_DIV   = DIV_1HZ,
  parameter int          SCN_W     = 2,
  parameter int          SCN_N     = 4,
  parameter int          SCN_PRE_W = SCN_PRE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             div_ld,
  input  logic [CNT_W-1:0] div_in,
  output logic             div_busy,
  output logic             div_err,
  output logic             cnt_tick,
  output logic             clk_cnt,
  output logic [SCN_W-1:0] clk_scn,
  output logic             scn_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_div_pend;
  logic             r_busy;
  logic             r_err;
  logic             r_tick;
  logic             r_clk_cnt;

  logic             w_ld_ok;
  logic             w_ld_zero;
  logic             w_tc;
  logic             w_wrap;

  assign w_ld_ok   = div_ld && (div_in != '0);
  assign w_ld_zero = div_ld && (div_in == '0);
  assign w_tc      = en && (r_cnt == (r_div_act - CNT_W'(1)));
  assign w_wrap    = clr || w_tc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div_act  <= CNT_W'(DEF_DIV);
      r_div_pend <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_tick     <= 1'b0;
      r_clk_cnt  <= 1'b0;
    end else begin
      r_err <= w_ld_zero;

      // A load arriving on the wrap cycle itself bypasses the pending register.
      if (w_wrap) begin
        if (w_ld_ok) begin
          r_div_act <= div_in;
        end else if (r_busy) begin
          r_div_act <= r_div_pend;
        end
        r_busy <= 1'b0;
      end else if (w_ld_ok) begin
        r_div_pend <= div_in;
        r_busy     <= 1'b1;
      end

      if (clr) begin
        r_cnt     <= '0;
        r_clk_cnt <= 1'b0;
        r_tick    <= 1'b0;
      end else if (en) begin
        if (w_tc) begin
          r_cnt     <= '0;
          r_tick    <= 1'b1;
          r_clk_cnt <= ~r_clk_cnt;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

  assign div_busy = r_busy;
  assign div_err  = r_err;
  assign cnt_tick = r_tick;
  assign clk_cnt  = r_clk_cnt;

  scan_cnt #(
    .SCN_W    (SCN_W),
    .SCN_N    (SCN_N),
    .SCN_PRE_W(SCN_PRE_W)
  ) u_scan_cnt (
    .clk     (clk),
    .rst     (rst),
    .clk_scn (clk_scn),
    .scn_tick(scn_tick)
  );

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed bench for freq_div_prog with a short default divisor and a fast 3-position scan.
module tb_freq_div_prog;

  localparam int CNT_W     = 8;
  localparam int SCN_W     = 2;
  localparam int SCN_N     = 3;
  localparam int SCN_PRE_W = 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic             clr;
  logic             div_ld;
  logic [CNT_W-1:0] div_in;
  logic             div_busy;
  logic             div_err;
  logic             cnt_tick;
  logic             clk_cnt;
  logic [SCN_W-1:0] clk_scn;
  logic             scn_tick;

  int n_cmp;
  int n_bad;
  int k;

  freq_div_prog #(
    .CNT_W    (CNT_W),
    .DEF_DIV  (4),
    .SCN_W    (SCN_W),
    .SCN_N    (SCN_N),
    .SCN_PRE_W(SCN_PRE_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .div_ld  (div_ld),
    .div_in  (div_in),
    .div_busy(div_busy),
    .div_err (div_err),
    .cnt_tick(cnt_tick),
    .clk_cnt (clk_cnt),
    .clk_scn (clk_scn),
    .scn_tick(scn_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {cnt_tick, clk_cnt, div_busy, div_err, clk_scn[1:0], scn_tick}
  typedef struct {
    logic       rst;
    logic       en;
    logic       clr;
    logic       ld;
    logic [7:0] din;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[33];

  function automatic logic [6:0] obs();
    return {cnt_tick, clk_cnt, div_busy, div_err, clk_scn, scn_tick};
  endfunction

  task automatic drive(input logic r, input logic e, input logic c, input logic l,
                       input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; clr = c; div_ld = l; div_in = d;
    @(posedge clk);
    #1;
    if (r) k = 0;
    else   k = k + 1;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d: got tick/clk/busy/err/scn/stick=%b required %b", name, k, got, exp);
    end
  endtask

  // Hand sequences: main outputs hand-computed, scan column from the 4-cycle/mod-3 rule.
  task automatic step(input string name, input logic r, input logic e, input logic c,
                      input logic l, input logic [7:0] d, input logic [3:0] exp_main);
    logic [1:0] s;
    logic       st;
    drive(r, e, c, l, d);
    s  = 2'((k / 4) % 3);
    st = (k != 0) && (k % 4 == 0);
    check(name, {exp_main, s, st});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; k = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; div_ld = 1'b0; div_in = '0;

    //              rst  en   clr  ld   din   tick clk busy err scn  stick
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,8'd0,{4'b0000,2'd0,1'b0}};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0000,2'd0,1'b0}};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0000,2'd0,1'b0}};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0000,2'd0,1'b0}};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1100,2'd1,1'b1}};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd1,1'b0}};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b1,8'd2,{4'b0110,2'd1,1'b0}};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b1,8'd0,{4'b0111,2'd1,1'b0}};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1000,2'd2,1'b1}};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0000,2'd2,1'b0}};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1100,2'd2,1'b0}};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd2,1'b0}};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b1,8'd3,{4'b1000,2'd0,1'b1}};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b1,8'd5,{4'b0010,2'd0,1'b0}};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b1,8'd6,{4'b0010,2'd0,1'b0}};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1100,2'd0,1'b0}};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd1,1'b1}};
    tbl[17] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd1,1'b0}};
    tbl[18] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd1,1'b0}};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd1,1'b0}};
    tbl[20] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd2,1'b1}};
    tbl[21] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1000,2'd2,1'b0}};
    tbl[22] = '{1'b0,1'b1,1'b0,1'b1,8'd2,{4'b0010,2'd2,1'b0}};
    tbl[23] = '{1'b0,1'b1,1'b1,1'b0,8'd0,{4'b0000,2'd2,1'b0}};
    tbl[24] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0000,2'd0,1'b1}};
    tbl[25] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1100,2'd0,1'b0}};
    tbl[26] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0100,2'd0,1'b0}};
    tbl[27] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1000,2'd0,1'b0}};
    tbl[28] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0000,2'd1,1'b1}};
    tbl[29] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b1100,2'd1,1'b0}};
    tbl[30] = '{1'b0,1'b1,1'b1,1'b0,8'd0,{4'b0000,2'd1,1'b0}};
    tbl[31] = '{1'b0,1'b1,1'b0,1'b0,8'd0,{4'b0000,2'd1,1'b0}};
    tbl[32] = '{1'b0,1'b1,1'b0,1'b1,8'd4,{4'b1100,2'd2,1'b1}};

    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].din);
      check($sformatf("tbl[%0d]", i), tbl[i].exp);
    end

    // Divisor 4, counter at 2, then 10 disabled cycles with a load issued while frozen.
    step("en_run",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0100);
    step("en_run",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0100);
    step("en_hold",  1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 4'b0110);
    for (int i = 0; i < 9; i++) begin
      step("en_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0110);
    end
    step("en_resume", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0110);
    step("en_tick",   1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1000);

    // Reset mid-period with a load pending: divisor must return to 4.
    step("rst_pend", 1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 4'b0010);
    step("rst",      1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step("rst_div", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0000);
    end
    step("rst_tick", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1100);
    for (int i = 0; i < 3; i++) begin
      step("rst_run", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0100);
    end

    // Divisor of 1: tick every enabled cycle, clk_cnt toggles every cycle.
    step("div1_ld", 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 4'b1000);
    step("div1",    1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1100);
    step("div1",    1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1000);
    step("div1",    1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b1100);
    step("div1_en0", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0100);
    step("err_en0",  1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 4'b0101);
    step("err_done", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
